// File: rtl/kanade_mem_responder.sv
// kanade_mem_responder
//   Memory-side responder for the multi-cycle core. Accepts one fetch/load/store
//   request at a time, performs it against a word-organised on-chip RAM and
//   answers with a one-cycle ack after a fixed wait.
//
//   Parameters
//     DEPTH_LOG2   log2 of RAM depth in 32-bit words
//     WAIT_CYCLES  cycles spent in WAIT between array access and ack (0..15)
//
//   Configuration macro
//     MEM_MISALIGN_TRAP_EN  defined: misaligned half/word requests fault
//                           undefined: misaligned low address bits forced to zero
//
//   Ports
//     clk      in   clock, all state on posedge
//     reset_n  in   synchronous active-low reset (RAM contents kept)
//     i_req    in   request strobe, sampled only while idle
//     i_we     in   1 = store, 0 = load/fetch
//     i_addr   in   byte address (little-endian)
//     i_size   in   00 byte, 01 half, 10/11 word
//     i_wdata  in   store data, right-justified
//     o_busy   out  request in flight
//     o_ack    out  one-cycle response pulse
//     o_rdata  out  load data, right-justified, zero-extended; valid with o_ack
//     o_fault  out  request rejected, qualified by o_ack
module kanade_mem_responder #(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_ack,
   output logic [31:0] o_rdata,
   output logic        o_fault
);

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   // Elaboration-time parameter sanity checks
   if (WAIT_CYCLES > ((1 << CNT_W) - 1)) begin : g_bad_wait
      $error("kanade_mem_responder: WAIT_CYCLES must be 0..15");
   end
   if ((DEPTH_LOG2 < 1) || (DEPTH_LOG2 > 29)) begin : g_bad_depth
      $error("kanade_mem_responder: DEPTH_LOG2 must be 1..29");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CNT_W-1:0]      r_cnt;
   logic                  r_we;
   logic [AW-1:0]         r_addr;
   logic [1:0]            r_size;
   logic [DW-1:0]         r_wdata;
   logic [DW-1:0]         r_hold_data;
   logic                  r_hold_fault;
   logic                  r_busy;
   logic                  r_ack;
   logic [DW-1:0]         r_rdata;
   logic                  r_fault;
   logic [DW-1:0]         r_mem [DEPTH];

   logic                  w_is_byte;
   logic                  w_is_half;
   logic                  w_oor;
   logic                  w_fault;
   logic [1:0]            w_lane;
   logic [3:0]            w_be;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [DW-1:0]         w_word;
   logic [DW-1:0]         w_shift;
   logic [DW-1:0]         w_wdata_sh;
   logic [DW-1:0]         w_load;
   logic [DW-1:0]         w_resp_data;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_req) w_next = S_ACCESS;
         S_ACCESS: w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
         S_WAIT:   if (r_cnt == CNT_W'(1)) w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Request capture; inputs are ignored once the request is accepted
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_size  <= 2'b00;
         r_wdata <= '0;
      end else if ((r_state == S_IDLE) && i_req) begin
         r_we    <= i_we;
         r_addr  <= i_addr;
         r_size  <= i_size;
         r_wdata <= i_wdata;
      end
   end

   // Wait counter: loaded at ACCESS, counts down through WAIT
   always_ff @(posedge clk) begin
      if (!reset_n)                 r_cnt <= '0;
      else if (r_state == S_ACCESS) r_cnt <= CNT_W'(WAIT_CYCLES);
      else if (r_state == S_WAIT)   r_cnt <= r_cnt - CNT_W'(1);
   end

   // Access decode from the latched request
   assign w_is_byte = (r_size == 2'b00);
   assign w_is_half = (r_size == 2'b01);
   assign w_oor     = |r_addr[AW-1:DEPTH_LOG2+2];
   assign w_idx     = r_addr[DEPTH_LOG2+1:2];

   // Misaligned low bits are forced to zero; with the trap enabled they fault instead
   assign w_lane = w_is_byte ? r_addr[1:0] :
                   w_is_half ? {r_addr[1], 1'b0} : 2'b00;

`ifdef MEM_MISALIGN_TRAP_EN
   logic w_misalign;
   assign w_misalign = (w_is_half && r_addr[0]) ||
                       (!w_is_byte && !w_is_half && (r_addr[1:0] != 2'b00));
   assign w_fault    = w_oor || w_misalign;
`else
   assign w_fault    = w_oor;
`endif

   assign w_be = w_is_byte ? (4'b0001 << w_lane) :
                 w_is_half ? (4'b0011 << w_lane) : 4'b1111;

   assign w_word      = r_mem[w_idx];
   assign w_shift     = w_word >> {w_lane, 3'b000};
   assign w_wdata_sh  = r_wdata << {w_lane, 3'b000};
   assign w_load      = w_is_byte ? {24'd0, w_shift[7:0]}  :
                        w_is_half ? {16'd0, w_shift[15:0]} : w_word;
   assign w_resp_data = (r_we || w_fault) ? '0 : w_load;

   // RAM write port: committed at the ACCESS edge, enabled lanes only
   always_ff @(posedge clk) begin
      if ((r_state == S_ACCESS) && r_we && !w_fault) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
         end
      end
   end

   // Access result held across WAIT
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hold_data  <= '0;
         r_hold_fault <= 1'b0;
      end else if (r_state == S_ACCESS) begin
         r_hold_data  <= w_resp_data;
         r_hold_fault <= w_fault;
      end
   end

   // Registered outputs; response comes straight from ACCESS when there is no wait
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_busy  <= 1'b0;
         r_ack   <= 1'b0;
         r_rdata <= '0;
         r_fault <= 1'b0;
      end else begin
         r_busy <= (w_next != S_IDLE);
         r_ack  <= (w_next == S_RESP);
         if (w_next == S_RESP) begin
            r_rdata <= (r_state == S_ACCESS) ? w_resp_data : r_hold_data;
            r_fault <= (r_state == S_ACCESS) ? w_fault     : r_hold_fault;
         end else begin
            r_rdata <= '0;
            r_fault <= 1'b0;
         end
      end
   end

   assign o_busy  = r_busy;
   assign o_ack   = r_ack;
   assign o_rdata = r_rdata;
   assign o_fault = r_fault;

endmodule
